// File: rtl/rotate_left_seq_32_bit.sv
// Multi-cycle 32-bit rotate-left: one bit position per clock for b cycles,
// with a start/busy/done handshake.
module rotate_left_seq_32_bit (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] in,
  input  logic [4:0]  b,
  output logic [31:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] data, data_nx;
  logic [4:0]  cnt, cnt_nx;

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      data  <= data_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    data_nx  = data;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: if (start) begin
        data_nx  = in;
        cnt_nx   = b;
        state_nx = (b == 5'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        data_nx  = {data[30:0], data[31]};
        cnt_nx   = cnt - 5'd1;
        // cnt==1 means this is the last shift
        if (cnt == 5'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign out  = data;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rotate_left_seq_32_bit.sv
// Bench for rotate_left_seq_32_bit: timing/result model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_rotate_left_seq_32_bit;

  logic        clock = 1'b0;
  logic        clear, start;
  logic [31:0] in;
  logic [4:0]  b;
  logic [31:0] out;
  logic        busy, done;

  int tests = 0;
  int fails = 0;

  rotate_left_seq_32_bit dut (
    .clock(clock), .clear(clear), .start(start), .in(in), .b(b),
    .out(out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
  endfunction

  // Model: an accepted start at edge N completes with done after edge N+b,
  // and the unit is free again after edge N+b+1.
  int          edge_n = 0;
  bit          seen_clear = 0;
  bit          m_active = 0, m_done = 0, m_known = 0;
  int          m_start = 0, m_b = 0;
  logic [31:0] m_res = '0, m_out = '0;

  always @(posedge clock) begin
    edge_n++;
    m_done = 0;
    if (clear) begin
      seen_clear = 1;
      m_active = 0;
      m_out = '0;
      m_known = 1;
    end else if (!m_active && start) begin
      m_active = 1;
      m_start = edge_n;
      m_b = int'(b);
      m_res = rotl(in, int'(b));
      m_known = 0;
    end else if (m_active && edge_n == m_start + m_b + 1) begin
      m_active = 0;
    end
    if (!clear && m_active && edge_n == m_start + m_b) begin
      m_done = 1;
      m_out = m_res;
      m_known = 1;
    end
  end

  always @(negedge clock) begin
    if (seen_clear) begin
      chk("busy", {31'b0, busy}, {31'b0, m_active});
      chk("done", {31'b0, done}, {31'b0, m_done});
      if (m_known) chk("out", out, m_out);
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic [31:0] x, input logic [4:0] n, input logic [31:0] exp);
    int w;
    in = x; b = n; start = 1'b1;
    tick();
    start = 1'b0;
    in = $urandom; b = 5'($urandom);
    w = 0;
    while (!done && w < 40) begin
      tick();
      w++;
    end
    chk("done_latency", w, {27'b0, n});
    chk("result", out, exp);
    tick();
    chk("busy_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    clear = 1'b1; start = 1'b1; in = 32'hFFFF_FFFF; b = 5'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_out", out, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
    end
    clear = 1'b0; start = 1'b0;
    tick();
    chk("idle_after_rst", {31'b0, busy}, 32'd0);

    run_op(32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    run_op(32'h1234_5678, 5'd4,  32'h2345_6781);
    run_op(32'h8000_0001, 5'd31, 32'hC000_0000);
    run_op(32'h0000_00FF, 5'd8,  32'h0000_FF00);
    run_op(32'hA5A5_0F0F, 5'd16, 32'h0F0F_A5A5);
    run_op(32'h0000_0001, 5'd1,  32'h0000_0002);

    // Busy lockout: second start at N+2 and in the DONE cycle are ignored
    in = 32'h1; b = 5'd5; start = 1'b1;
    tick();                                   // edge N
    start = 1'b0; tick();                     // N+1
    in = 32'hFFFF_FFFF; b = 5'd1; start = 1'b1;
    tick();                                   // N+2
    start = 1'b0;
    tick(); tick();                           // N+3, N+4
    chk("lock_no_early_done", {31'b0, done}, 32'd0);
    tick();                                   // N+5
    chk("lock_done", {31'b0, done}, 32'd1);
    chk("lock_out", out, 32'h0000_0020);
    start = 1'b1;
    tick();                                   // N+6, DONE cycle closes
    start = 1'b0;
    chk("lock_idle", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lock_no_second", {31'b0, done | busy}, 32'd0);
    end
    chk("lock_out_hold", out, 32'h0000_0020);

    // Mid-operation clear
    in = 32'h0000_0003; b = 5'd20; start = 1'b1;
    tick();                                   // N
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();       // N+1..N+6
    chk("mid_busy", {31'b0, busy}, 32'd1);
    clear = 1'b1;
    tick();                                   // N+7
    clear = 1'b0;
    chk("clr_out", out, 32'h0);
    chk("clr_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("clr_no_done", {31'b0, done}, 32'd0);
    end
    run_op(32'h0000_0001, 5'd1, 32'h0000_0002);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
